// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, control FSM state enumeration
// and pc_src encodings. Used by the control unit, the datapath and ALU decode.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;  // PC + 2
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;  // branch target
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;  // jump target

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit.
// Sequences each instruction through FETCH, DECODE, EXEC, MEM, WB (or HALT)
// and drives the datapath strobes/selects for every cycle.
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   opcode         : instr[15:12] from the instruction register
//   zero           : ALU zero flag (BEQ decision)
//   mem_ready      : memory access completes this cycle
//   mem_read, mem_write, ir_write, pc_write, reg_write, mem_to_reg, alu_src
//                  : datapath strobes and selects
//   pc_src         : next-PC select (cpu_pkg PC_SRC_*)
//   alu_op         : ALU operation request to ALU decode
//   halted, illegal: status flags (sticky until reset)
//   retired        : retired-instruction count, wraps
//   state          : current FSM state (debug visibility)
//
// Memory handshake: mem_ready is a completion strobe. A request
// (mem_read or mem_write) stays asserted every cycle until the cycle in
// which mem_ready=1; that cycle completes the access and the FSM advances.
// mem_ready is ignored in cycles with no request.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       pc_src,
  output logic [OP_W-1:0]  alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output state_t           state
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic              illegal_q, halted_q;
  logic [CNT_W-1:0]  retired_q;
  logic              retire, set_illegal, set_halt;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    is_legal = (op == OP_W'(OP_HALT)) || (op <= OP_W'(OP_JMP));
  endfunction

  always_comb begin
    state_d     = state_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src     = 1'b0;
    pc_src      = PC_SRC_SEQ;
    alu_op      = '0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_halt    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_SEQ;
          state_d  = S_DECODE;
        end
      end
      // Decision uses the live IR opcode; later states use op_q.
      S_DECODE: begin
        if (opcode == OP_W'(OP_HALT)) begin
          set_halt = 1'b1;
          state_d  = S_HALT;
        end else if (!is_legal(opcode)) begin
          set_illegal = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_AND), OP_W'(OP_OR): begin
            alu_op  = op_q;
            state_d = S_WB;
          end
          OP_W'(OP_LW), OP_W'(OP_SW): begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_W'(OP_BEQ): begin
            alu_op   = OP_W'(OP_SUB);
            pc_write = zero;
            pc_src   = PC_SRC_BRANCH;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          OP_W'(OP_JMP): begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (op_q == OP_W'(OP_SW)) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_W'(OP_LW));
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Strobes are forced off for as long as reset is held, independent of clk.
    if (!rst_n) begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src     = 1'b0;
      pc_src      = PC_SRC_SEQ;
      alu_op      = '0;
      retire      = 1'b0;
      set_illegal = 1'b0;
      set_halt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_halt) halted_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule
